// File: rtl/led_pkg.sv
// Shared constants and types for the multi-channel LED pattern generator.
// Mode encodings match the two-bit per-channel MODE field.
package led_pkg;

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_ch.sv
// One LED channel: duty select, breathe scaling, PWM compare and
// registered, polarity-adjusted output.
module led_pwm_ch
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] bright,
  input  logic                blink_ph,
  input  logic [PWM_BITS-1:0] ramp,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                inv,
  output logic                led
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [2*PWM_BITS-1:0] prod;
  logic [PWM_BITS-1:0]   duty;
  logic                  lit;

  assign prod = {{PWM_BITS{1'b0}}, ramp}
              * {{PWM_BITS{1'b0}}, bright};

  always_comb begin
    duty = '0;
    unique case (1'b1)
      (mode == MODE_OFF):     duty = '0;
      (mode == MODE_ON):      duty = bright;
      (mode == MODE_BLINK):   duty = blink_ph ? bright : '0;
      (mode == MODE_BREATHE): duty = prod[2*PWM_BITS-1:PWM_BITS];
      default:                duty = '0;
    endcase
  end

  // Full duty must stay lit through the pwm_cnt == MAX slot.
  assign lit = (duty == MAX) || (pwm_cnt < duty);

  always_ff @(posedge CLK) begin
    if (!RST_N) led <= inv;
    else        led <= lit ^ inv;
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: shared prescaler, blink and breathe
// timebases and PWM counter feeding one led_pwm_ch per channel.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int                NUM_CH      = 5,
  parameter int                CLK_HZ      = 12000000,
  parameter int                TICK_HZ     = 1000,
  parameter int                BLINK_TICKS = 500,
  parameter int                PWM_BITS    = 8,
  parameter logic [NUM_CH-1:0] ACTIVE_LOW  = '0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [2*NUM_CH-1:0]   MODE,
  input  logic [PWM_BITS-1:0]   BRIGHT,
  output logic [NUM_CH-1:0]     LED,
  output logic                  TICK
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = cnt_w(DIV);
  localparam int BW  = cnt_w(BLINK_TICKS);

  localparam logic [PW-1:0]       PRESC_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [PWM_BITS-1:0] MAX        = '1;
  localparam logic [PWM_BITS-1:0] ONE        = PWM_BITS'(1);

  logic [PW-1:0]       presc;
  logic [BW-1:0]       blink_cnt;
  logic                blink_ph;
  logic [PWM_BITS-1:0] ramp, ramp_d;
  logic [PWM_BITS-1:0] pwm_cnt;
  dir_e                dir, dir_d;

  assign TICK = (presc == PRESC_LAST);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc     <= '0;
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      pwm_cnt   <= '0;
    end else begin
      presc   <= TICK ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      if (TICK) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
    end
  end

  // Triangle ramp: turn around at the ends without dwelling.
  always_comb begin
    ramp_d = ramp;
    dir_d  = dir;
    if (TICK) begin
      unique case (dir)
        DIR_UP: begin
          if (ramp == MAX) begin
            dir_d  = DIR_DOWN;
            ramp_d = MAX - ONE;
          end else begin
            ramp_d = ramp + ONE;
          end
        end
        DIR_DOWN: begin
          if (ramp == '0) begin
            dir_d  = DIR_UP;
            ramp_d = ONE;
          end else begin
            ramp_d = ramp - ONE;
          end
        end
        default: begin
          dir_d  = DIR_UP;
          ramp_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      ramp <= '0;
      dir  <= DIR_UP;
    end else begin
      ramp <= ramp_d;
      dir  <= dir_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    led_pwm_ch #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .mode     (MODE[2*i+1:2*i]),
      .bright   (BRIGHT),
      .blink_ph (blink_ph),
      .ramp     (ramp),
      .pwm_cnt  (pwm_cnt),
      .inv      (ACTIVE_LOW[i]),
      .led      (LED[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen against a time-based
// reference model (timebases derived from cycles since reset).
module tb_led_pattern_gen;

  localparam logic [4:0] AL = 5'b00001;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [9:0] MODE = '0;
  logic [3:0] BRIGHT = '0;
  logic [4:0] LED;
  logic       TICK;

  int checks = 0;
  int errors = 0;
  int t = 0;

  always #5 CLK = ~CLK;

  led_pattern_gen #(
    .NUM_CH      (5),
    .CLK_HZ      (100),
    .TICK_HZ     (10),
    .BLINK_TICKS (3),
    .PWM_BITS    (4),
    .ACTIVE_LOW  (AL)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .MODE   (MODE),
    .BRIGHT (BRIGHT),
    .LED    (LED),
    .TICK   (TICK)
  );

  // LED value registered at the end of cycle tc (tc cycles after reset).
  function automatic logic [4:0] model_led(input int tc,
                                           input logic [9:0] md,
                                           input logic [3:0] br);
    int k, ph, m, rp, pw, d;
    logic [4:0] r;
    k  = tc / 10;
    ph = (k / 3) % 2;
    m  = k % 30;
    rp = (m <= 15) ? m : 30 - m;
    pw = tc % 16;
    r  = '0;
    for (int i = 0; i < 5; i++) begin
      case (md[2*i +: 2])
        2'b00:   d = 0;
        2'b01:   d = int'(br);
        2'b10:   d = ph ? int'(br) : 0;
        default: d = (rp * int'(br)) / 16;
      endcase
      r[i] = ((d == 15) || (pw < d)) ^ AL[i];
    end
    return r;
  endfunction

  task automatic step();
    logic [4:0] e;
    logic       et;
    if (!RST_N) begin
      e = AL;
      t = 0;
    end else begin
      e = model_led(t, MODE, BRIGHT);
      t = t + 1;
    end
    et = (t % 10 == 9);
    @(posedge CLK);
    #1;
    checks++;
    assert (LED === e) else begin
      errors++;
      $error("FAIL led t=%0d got %b exp %b", t, LED, e);
    end
    checks++;
    assert (TICK === et) else begin
      errors++;
      $error("FAIL tick t=%0d got %b exp %b", t, TICK, et);
    end
  endtask

  initial begin
    int hi;
    int guard;

    // Reset held with all channels on at full brightness.
    MODE   = 10'b01_01_01_01_01;
    BRIGHT = 4'd15;
    RST_N  = 1'b0;
    repeat (5) step();
    RST_N = 1'b1;
    repeat (25) step();

    // ON duty at several brightness levels.
    repeat (20) step();
    BRIGHT = 4'd4;
    hi = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      hi += int'(LED[1]);
    end
    checks++;
    assert (hi == 8) else begin
      errors++;
      $error("FAIL on_duty4 got %0d exp %0d", hi, 8);
    end
    BRIGHT = 4'd0;
    repeat (16) step();

    // Blink on ch0, breathe on ch1.
    BRIGHT = 4'd15;
    MODE   = 10'b00_00_00_00_10;
    repeat (200) step();
    MODE = 10'b00_00_00_11_00;
    repeat (700) step();

    // Polarity on the inverted channel.
    MODE = 10'b00_00_00_00_00;
    repeat (5) step();
    MODE = 10'b00_00_00_00_01;
    repeat (5) step();

    // Reset while ramp is 9 on the way down.
    MODE  = 10'b00_00_00_11_00;
    guard = 0;
    while (((t / 10) % 30) != 21 && guard < 400) begin
      step();
      guard++;
    end
    checks++;
    assert (guard < 400) else begin
      errors++;
      $error("FAIL ramp9_wait got %0d exp <400", guard);
    end
    RST_N = 1'b0;
    repeat (2) step();
    RST_N = 1'b1;
    repeat (60) step();

    // Randomized modes, brightness and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 7) == 0) begin
        MODE   = 10'($urandom);
        BRIGHT = 4'($urandom);
      end
      RST_N = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
